// File: rtl/tw_mul_pair.sv
// tw_mul_pair: two-lane Goldilocks (p = 2^64 - 2^32 + 1) modular multiplier
// fed by the twiddle ROM. Six-register pipeline: align, twiddle select,
// partial products, product sum, first fold, canonicalisation. A result
// counter flags the end of every BLK_LEN-result block.
module tw_mul_pair #(
  parameter int P_WIDTH = 128,
  parameter int LANE_W  = 64,
  parameter int BLK_LEN = 16,
  parameter int CNT_W   = 4
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] data_in,
  input  logic               use_const,
  input  logic [P_WIDTH-1:0] tw_in,
  input  logic [P_WIDTH-1:0] tw_const_in,
  input  logic               flush,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] data_out,
  output logic               blk_done
);

  localparam int NLANE  = P_WIDTH / LANE_W;
  localparam int HALF_W = LANE_W / 2;
  localparam logic [LANE_W-1:0] GOLD_P   = 64'hFFFF_FFFF_0000_0001;
  // 2^64 mod p, also the correction applied when c - a borrows
  localparam logic [LANE_W-1:0] EPS      = 64'h0000_0000_FFFF_FFFF;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLK_LEN - 1);

  // 32x32 -> 64 unsigned multiply
  function automatic logic [LANE_W-1:0] mul_half(input logic [HALF_W-1:0] a,
                                                 input logic [HALF_W-1:0] b);
    logic [LANE_W-1:0] ax, bx;
    ax = {{HALF_W{1'b0}}, a};
    bx = {{HALF_W{1'b0}}, b};
    return ax * bx;
  endfunction

  // Recombine four partial products into the full 128-bit product
  function automatic logic [2*LANE_W-1:0] sum_pp(input logic [LANE_W-1:0] ll,
                                                 input logic [LANE_W-1:0] lh,
                                                 input logic [LANE_W-1:0] hl,
                                                 input logic [LANE_W-1:0] hh);
    logic [2*LANE_W-1:0] mid;
    mid = ({{LANE_W{1'b0}}, lh} + {{LANE_W{1'b0}}, hl}) << HALF_W;
    return {hh, ll} + mid;
  endfunction

  // t = c - a mod p, using 2^96 == -1; result fits 64 bits, may be >= p
  function automatic logic [LANE_W-1:0] fold_t(input logic [2*LANE_W-1:0] x);
    logic [LANE_W-1:0] a, c, t;
    a = {{HALF_W{1'b0}}, x[2*LANE_W-1 -: HALF_W]};
    c = x[LANE_W-1:0];
    t = c - a;
    if (c < a) t = t - EPS;
    return t;
  endfunction

  // u = b * (2^32 - 1), using 2^64 == 2^32 - 1
  function automatic logic [LANE_W-1:0] fold_u(input logic [HALF_W-1:0] b);
    return {b, {HALF_W{1'b0}}} - {{HALF_W{1'b0}}, b};
  endfunction

  // s = t + u brought into [0, p); the 65-bit compare covers the carry-out case
  function automatic logic [LANE_W-1:0] canon(input logic [LANE_W-1:0] t,
                                              input logic [LANE_W-1:0] u);
    logic [LANE_W:0] s, pe;
    pe = {1'b0, GOLD_P};
    s  = {1'b0, t} + {1'b0, u};
    for (int i = 0; i < 2; i++) begin
      if (s >= pe) s = s - pe;
    end
    return s[LANE_W-1:0];
  endfunction

  logic               vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic [CNT_W-1:0]   cnt;
  logic [P_WIDTH-1:0] data_p0, data_p1, tw_p1;
  logic               uc_p0;

  // Valid pipeline, result counter and block-done pulse
  always_ff @(posedge CLK) begin
    if (!rst_n || flush) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      vld_p4    <= 1'b0;
      out_valid <= 1'b0;
      blk_done  <= 1'b0;
      cnt       <= '0;
    end else begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      vld_p4    <= vld_p3;
      out_valid <= vld_p4;
      blk_done  <= vld_p4 && (cnt == CNT_LAST);
      if (vld_p4) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // ---- A0: align data with the ROM request cycle
  always_ff @(posedge CLK) begin
    if (in_valid) begin
      data_p0 <= data_in;
      uc_p0   <= use_const;
    end
  end

  // ---- A1: ROM Q is valid now; pick stage or constant twiddle
  always_ff @(posedge CLK) begin
    if (vld_p0) begin
      data_p1 <= data_p0;
      tw_p1   <= uc_p0 ? tw_const_in : tw_in;
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    logic [LANE_W-1:0]   d_l, w_l;
    logic [LANE_W-1:0]   pp_ll_p2, pp_lh_p2, pp_hl_p2, pp_hh_p2;
    logic [2*LANE_W-1:0] x_p3;
    logic [LANE_W-1:0]   t_p4, u_p4, res_p5;

    assign d_l = data_p1[g*LANE_W +: LANE_W];
    assign w_l = tw_p1[g*LANE_W +: LANE_W];

    // ---- M1: partial products
    always_ff @(posedge CLK) begin
      if (vld_p1) begin
        pp_ll_p2 <= mul_half(d_l[HALF_W-1:0],      w_l[HALF_W-1:0]);
        pp_lh_p2 <= mul_half(d_l[HALF_W-1:0],      w_l[LANE_W-1:HALF_W]);
        pp_hl_p2 <= mul_half(d_l[LANE_W-1:HALF_W], w_l[HALF_W-1:0]);
        pp_hh_p2 <= mul_half(d_l[LANE_W-1:HALF_W], w_l[LANE_W-1:HALF_W]);
      end
    end

    // ---- M2: full 128-bit product
    always_ff @(posedge CLK) begin
      if (vld_p2) x_p3 <= sum_pp(pp_ll_p2, pp_lh_p2, pp_hl_p2, pp_hh_p2);
    end

    // ---- R1: fold the upper 64 bits into two 64-bit terms
    always_ff @(posedge CLK) begin
      if (vld_p3) begin
        t_p4 <= fold_t(x_p3);
        u_p4 <= fold_u(x_p3[LANE_W +: HALF_W]);
      end
    end

    // ---- R2: add and canonicalise into the output register
    always_ff @(posedge CLK) begin
      if (!rst_n)                res_p5 <= '0;
      else if (vld_p4 && !flush) res_p5 <= canon(t_p4, u_p4);
    end

    assign data_out[g*LANE_W +: LANE_W] = res_p5;
  end

endmodule

// File: tb/tb_tw_mul_pair.sv
// Bench for tw_mul_pair: directed and randomised lane pairs checked every
// cycle against a plain (d*w) % p model with a 6-cycle latency queue.
module tb_tw_mul_pair;

  localparam logic [63:0] GP = 64'hFFFF_FFFF_0000_0001;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] data_in = '0;
  logic         use_const = 1'b0;
  logic [127:0] tw_in = '0;
  logic [127:0] tw_const_in = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [127:0] data_out;
  logic         blk_done;

  tw_mul_pair dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .use_const(use_const), .tw_in(tw_in), .tw_const_in(tw_const_in),
    .flush(flush), .out_valid(out_valid), .data_out(data_out),
    .blk_done(blk_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           due;
    logic [127:0] val;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           mcnt = 0;
  int           blk_seen = 0;
  logic         pend_v = 1'b0;
  logic [127:0] pend_d = '0;
  logic         pend_uc = 1'b0;
  logic [127:0] last_out = '0;
  logic         exp_v, exp_blk;
  logic [127:0] nx_tw = '0;
  logic [127:0] nx_twc = '0;

  function automatic logic [127:0] mulpair(input logic [127:0] d, input logic [127:0] w);
    logic [127:0] r, prod, pm;
    r  = '0;
    pm = {64'd0, GP};
    for (int l = 0; l < 2; l++) begin
      prod = {64'd0, d[l*64 +: 64]} * {64'd0, w[l*64 +: 64]};
      prod = prod % pm;
      r[l*64 +: 64] = prod[63:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rlane();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = GP - 64'd1;
      1:       v = GP;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      3:       v = 64'd0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Model of one clock edge: inputs at this edge are stable bench values
  task automatic model_edge();
    cyc++;
    exp_v   = 1'b0;
    exp_blk = 1'b0;
    if (!rst_n || flush) begin
      q.delete();
      pend_v = 1'b0;
      mcnt   = 0;
      if (!rst_n) last_out = '0;
    end else begin
      if (pend_v) q.push_back('{due: cyc + 4, val: mulpair(pend_d, pend_uc ? tw_const_in : tw_in)});
      pend_v  = in_valid;
      pend_d  = data_in;
      pend_uc = use_const;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_v    = 1'b1;
        last_out = q[0].val;
        void'(q.pop_front());
        mcnt++;
        if (mcnt == 16) begin
          exp_blk = 1'b1;
          mcnt    = 0;
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_v});
    chk("blk_done", {127'd0, blk_done}, {127'd0, exp_blk});
    chk("data_out", data_out, last_out);
    if (blk_done === 1'b1) blk_seen++;
  endtask

  // One cycle: drive at negedge (twiddles lag data by one cycle), model and check after posedge
  task automatic step(input logic iv, input logic [127:0] d, input logic uc,
                      input logic [127:0] tw, input logic [127:0] twc,
                      input logic rn, input logic fl);
    @(negedge CLK);
    in_valid    = iv;
    data_in     = d;
    use_const   = uc;
    rst_n       = rn;
    flush       = fl;
    tw_in       = nx_tw;
    tw_const_in = nx_twc;
    nx_tw       = tw;
    nx_twc      = twc;
    @(posedge CLK);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, rnd128(), 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'b1, 1'b0);
  endtask

  task automatic item(input logic [127:0] d, input logic uc,
                      input logic [127:0] tw, input logic [127:0] twc);
    step(1'b1, d, uc, tw, twc, 1'b1, 1'b0);
  endtask

  task automatic rnd_items(input int n);
    repeat (n) item({rlane(), rlane()}, 1'($urandom_range(0, 1)),
                    {rlane(), rlane()}, {rlane(), rlane()});
  endtask

  int blk_base;

  initial begin
    // Model pinned to hand-computed products
    chk("pin_t1", mulpair({64'd2, 64'd3}, {64'd1, 64'd1}), {64'd2, 64'd3});
    chk("pin_t2", mulpair({GP - 64'd1, 64'h1_0000_0000}, {GP - 64'd1, 64'h1_0000_0000}),
        {64'h1, 64'h0000_0000_FFFF_FFFF});
    chk("pin_t3", mulpair({64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, {64'd1, 64'hFFFF_FFFF_FFFF_FFFF}),
        {64'h0000_0000_FFFF_FFFE, 64'd0});
    chk("pin_t4", mulpair({64'd128, 64'd5}, {64'h0200_0000_0000_0000, 64'd1}),
        {64'h0000_0000_FFFF_FFFF, 64'd5});

    // Reset: all outputs low
    repeat (3) step(1'b1, rnd128(), 1'b0, rnd128(), rnd128(), 1'b0, 1'b0);

    // Directed products
    item({64'd2, 64'd3}, 1'b0, {64'd1, 64'd1}, rnd128());
    idle(8);
    item({GP - 64'd1, 64'h1_0000_0000}, 1'b0, {GP - 64'd1, 64'h1_0000_0000}, rnd128());
    idle(8);
    item({64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, 1'b0, {64'd1, 64'hFFFF_FFFF_FFFF_FFFF}, rnd128());
    idle(8);
    item({64'd128, 64'd5}, 1'b1, rnd128(), {64'h0200_0000_0000_0000, 64'd1});
    idle(8);

    // Flush clears the counter; an in_valid in the flush cycle is dropped
    step(1'b1, rnd128(), 1'b0, rnd128(), rnd128(), 1'b1, 1'b1);
    idle(8);

    // 40 back-to-back random items: blk_done on results 16 and 32
    blk_base = blk_seen;
    rnd_items(40);
    idle(8);
    chk("blk_count_40", 128'(blk_seen - blk_base), 128'd2);

    // Reset with 3 items in flight, then one full block
    rnd_items(3);
    step(1'b0, rnd128(), 1'b0, rnd128(), rnd128(), 1'b0, 1'b0);
    idle(8);
    blk_base = blk_seen;
    rnd_items(16);
    idle(8);
    chk("blk_after_rst", 128'(blk_seen - blk_base), 128'd1);

    // Flush with 3 items in flight, then one full block
    rnd_items(3);
    step(1'b0, rnd128(), 1'b0, rnd128(), rnd128(), 1'b1, 1'b1);
    idle(8);
    blk_base = blk_seen;
    rnd_items(5);
    idle(2);
    rnd_items(11);
    idle(8);
    chk("blk_after_flush", 128'(blk_seen - blk_base), 128'd1);

    chk("drain", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tw_mul_pair.md
Name: tw_mul_pair

Overview:
Downstream consumer of the 128-bit twiddle ROM output. It multiplies two 64-bit data lanes by the two packed 64-bit twiddles, modulo the Goldilocks prime p = 0xFFFFFFFF00000001, and returns canonical residues.
- Per-lane twiddle source is either the stage twiddle word or the constant twiddle word.
- The block compensates for the ROM's 1-cycle registered output latency.
- Fully pipelined, one lane pair per cycle, and it counts results to flag block completion to the stage controller.

Parameters:
P_WIDTH, 128, packed width of the data and twiddle words (two 64-bit lanes; hi lane = [127:64], lo lane = [63:0]).
LANE_W, 64, lane width; fixed by the modulus.
BLK_LEN, 16, results per block before blk_done pulses.
CNT_W, 4, width of the result counter; must satisfy 2^CNT_W >= BLK_LEN.

Ports:
CLK  input  1  clock, all logic on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  data_in is valid this cycle; the twiddle ROM is enabled in the same cycle (CEN low).
data_in  input  P_WIDTH  two packed data lanes.
use_const  input  1  sampled with data_in; 1 selects tw_const_in, 0 selects tw_in.
tw_in  input  P_WIDTH  twiddle ROM Q; sampled one cycle after in_valid.
tw_const_in  input  P_WIDTH  twiddle ROM Q_const; sampled one cycle after in_valid.
flush  input  1  synchronous clear of all valid bits and the counter.
out_valid  output  1  data_out holds a result.
data_out  output  P_WIDTH  packed products, each a canonical value in [0,p).
blk_done  output  1  one-cycle pulse on the BLK_LEN-th result of a block.

Behaviour:
- Reset (rst_n low at an edge):
  - out_valid=0, data_out=0, blk_done=0.
  - All pipeline valid bits and the result counter clear.
  - Reset applied mid-operation discards all in-flight items; no result from them ever appears.
- flush: same effect as reset on valid bits, the counter and blk_done. Data registers may keep stale values. flush takes priority over a simultaneous in_valid, which is dropped.
- Stage A0 (align): on in_valid, register data_in and use_const with valid a0_v.
- Stage A1 (twiddle select): in the following cycle, select the twiddle per lane:
  - twiddle = use_const_r ? tw_const_in : tw_in, sampled in this cycle.
  - This matches the ROM's registered Q, which appears one cycle after CEN.
- M1: four 32x32 partial products per lane, registered.
- M2: partial products summed into a 128-bit product x per lane, registered.
- R1 reduction, with x = a·2^96 + b·2^64 + c (a, b 32-bit; c 64-bit):
  - t = c − a. If this borrows, add p (equivalently, subtract 2^32−1).
  - u = b·(2^32−1), i.e. (b<<32) − b.
  - Register both t and u.
- R2: s = t + u. If it carries out, or s ≥ p, subtract p; repeat once if still ≥ p. Register s into data_out.
- Latency: an item with in_valid in cycle n produces out_valid=1 in cycle n+6 (align, select, M1, M2, R1, R2). Throughput is 1 per cycle; back-to-back in_valid is legal and there is no backpressure.
- Operands: the full 64-bit range is accepted, including values ≥ p (e.g. 2^64−1). The output is always reduced to [0,p).
- Lanes are independent and share the valid pipeline.
- out_valid is deasserted when no item is present. data_out holds its last value when out_valid=0.
- Result counter:
  - Increments on each out_valid.
  - On the result that brings it to BLK_LEN, blk_done=1 in the same cycle as that out_valid, and the counter wraps to 0.
  - blk_done is never high without out_valid.

Test Plan:
1. Reset, then in_valid with data_in={64'd2,64'd3}, tw_in={64'd1,64'd1} applied one cycle later → cycle n+6 gives out_valid=1, data_out={2,3}; all outputs 0 during reset.
2. Lanes {p−1,2^32}, twiddles {p−1,2^32} → {0x0000000000000001, 0x00000000FFFFFFFF}.
3. Lanes {0xFFFFFFFFFFFFFFFF, 0}, twiddles {1,0xFFFFFFFFFFFFFFFF} → {0x00000000FFFFFFFE, 0}. Checks non-canonical inputs.
4. use_const=1 with tw_const_in={0x0200000000000000,1}, tw_in=garbage, data={2^7,5} → {2^64 mod p = 0x00000000FFFFFFFF, 5}. Check tw_in is ignored.
5. 40 back-to-back inputs with random values against a software model → 40 consecutive out_valid cycles, all results matching; blk_done pulses on results 16 and 32 only.
6. Assert rst_n low for 1 cycle (or flush) while 3 items are in flight → no out_valid from those items; counter restarts so the next blk_done comes after 16 new results.
